itrx_amba4_apb_master: RTL
==========================

// Module: itrx_amba4_apb_master
// PURPOSE
//  Parametrised AMBA4 APB requester/bridge: takes single-beat requests on a valid/ready port,
//  decodes the target among NS slaves, and drives a full APB4 SETUP/ACCESS transfer.
//  Adds wait-state handling, a bus timeout, decode errors and APB4 pstrb/pprot.
//  Sits between a register-access master (CSR/JTAG/uC) and the APB fabric.
// PARAMETERS
//  PDATAW  32  APB data width; 8,16,32 or 64. PSTRBW = PDATAW/8
//  NS      16  number of slaves; 1..32. IDXW = (NS>1) ? $clog2(NS) : 1
//  SLVAW   12  address bits per slave window; slave index = req_addr[SLVAW +: IDXW]
//  TMO_CYC 256 max ACCESS cycles waiting for pready before timeout; >=2
// PORTS
//  pclk       in   1            APB clock; every flop on rising edge
//  preset_n   in   1            synchronous active-low reset
//  req_valid  in   1            request valid
//  req_ready  out  1            request accepted when req_valid & req_ready
//  req_addr   in   32           byte address
//  req_write  in   1            1 = write, 0 = read
//  req_wdata  in   PDATAW       write data
//  req_strb   in   PSTRBW       write byte strobes
//  req_prot   in   3            APB4 pprot
//  rsp_valid  out  1            one-cycle response pulse
//  rsp_rdata  out  PDATAW       read data; 0 for writes and errors
//  rsp_err    out  1            1 = pslverr, decode error or timeout
//  rsp_tmo    out  1            1 = error was a timeout (qualifies rsp_err)
//  paddr      out  32           APB address
//  pwrite     out  1            APB direction
//  pwdata     out  PDATAW       APB write data
//  pstrb      out  PSTRBW       APB strobes
//  pprot      out  3            APB protection
//  psel       out  NS           one-hot slave select
//  penable    out  1            APB enable
//  prdata     in   NS*PDATAW    per-slave read data; slave i at [i*PDATAW +: PDATAW]
//  pready     in   NS           per-slave ready
//  pslverr    in   NS           per-slave error
// BEHAVIOUR
//  Reset (preset_n low at an edge): state IDLE. All outputs 0 except req_ready = 1.
//   Also applies mid-transfer: psel/penable drop the next edge, no rsp_valid is produced.
//  FSM states: IDLE, SETUP, ACCESS, DERR.
//   IDLE:   req_ready = 1. On accept, register addr/write/wdata/strb/prot.
//           Index < NS -> SETUP. Index >= NS -> DERR.
//   SETUP:  psel[idx] = 1, penable = 0 -> ACCESS.
//   ACCESS: psel[idx] = 1, penable = 1. Sample the selected pready/pslverr/prdata each edge.
//           pready = 1 -> IDLE. Capture rdata (reads only) and err = pslverr.
//           Timeout counter reaches TMO_CYC-1 with pready = 0 -> IDLE, err = 1, tmo = 1.
//   DERR:   no psel. -> IDLE with err = 1, rdata = 0.
//  rsp_valid is registered and pulses the cycle after leaving ACCESS or DERR. That cycle
//   is IDLE, so a new request may be accepted in the same cycle (back-to-back).
//  Min latency: accept edge T -> SETUP T+1 -> ACCESS T+2 (pready = 1) -> rsp_valid T+3.
//   Throughput: 1 transfer per 3 cycles with zero wait states.
//  paddr/pwrite/pwdata/pstrb/pprot are held stable from SETUP through the end of ACCESS.
//  pstrb is forced to 0 on reads. pwdata and rsp_rdata are 0 when unused.
//  Timeout counter: IDXW-independent, width $clog2(TMO_CYC). Cleared on SETUP entry.
//   Increments each ACCESS cycle with pready = 0. Saturates, never wraps.
//  Unselected slaves' pready/pslverr/prdata are ignored. req_* is ignored outside IDLE.
// TESTING
//  1. Write 0xDEADBEEF to 0x0000_3010, strb 0xF, slave 3 pready tied 1 ->
//     psel = 0x0008 for 2 cycles, penable in the 2nd, rsp_valid at T+3, err = 0.
//  2. Read 0x0000_5004, slave 5 holds pready = 0 for 4 cycles then returns 0x1234_5678 ->
//     ACCESS lasts 5 cycles, rsp_rdata = 0x12345678, pstrb = 0 throughout.
//  3. NS = 4, address 0x0000_7000 (index 7) -> no psel ever, rsp_valid at T+2, rsp_err = 1, rsp_rdata = 0.
//  4. TMO_CYC = 8, pready stuck 0 -> penable high exactly 8 cycles, rsp_err = 1, rsp_tmo = 1, back in IDLE.
//  5. Slave asserts pslverr with pready -> rsp_err = 1, rsp_tmo = 0. A queued request is accepted
//     in the rsp_valid cycle and its SETUP starts the next cycle.
//  6. preset_n low during ACCESS -> psel/penable 0 next edge, no rsp_valid, req_ready = 1 after release.

Source files
------------

// File: rtl/itrx_amba4_apb_master.sv
// APB4 requester: accepts single-beat requests, decodes one of NS slaves and runs a
// SETUP/ACCESS transfer with wait states, timeout and decode-error responses.
module itrx_amba4_apb_master #(
  parameter int unsigned PDATAW  = 32,
  parameter int unsigned NS      = 16,
  parameter int unsigned SLVAW   = 12,
  parameter int unsigned TMO_CYC = 256,
  localparam int unsigned PSTRBW = PDATAW / 8
) (
  input  logic                 i_pclk,
  input  logic                 i_preset_n,
  // request port
  input  logic                 i_req_valid,
  output logic                 o_req_ready,
  input  logic [31:0]          i_req_addr,
  input  logic                 i_req_write,
  input  logic [PDATAW-1:0]    i_req_wdata,
  input  logic [PSTRBW-1:0]    i_req_strb,
  input  logic [2:0]           i_req_prot,
  // response port
  output logic                 o_rsp_valid,
  output logic [PDATAW-1:0]    o_rsp_rdata,
  output logic                 o_rsp_err,
  output logic                 o_rsp_tmo,
  // APB4 fabric
  output logic [31:0]          o_paddr,
  output logic                 o_pwrite,
  output logic [PDATAW-1:0]    o_pwdata,
  output logic [PSTRBW-1:0]    o_pstrb,
  output logic [2:0]           o_pprot,
  output logic [NS-1:0]        o_psel,
  output logic                 o_penable,
  input  logic [NS*PDATAW-1:0] i_prdata,
  input  logic [NS-1:0]        i_pready,
  input  logic [NS-1:0]        i_pslverr
);

  localparam int unsigned IDXW = (NS > 1) ? $clog2(NS) : 1;
  localparam int unsigned TMOW = $clog2(TMO_CYC);
  localparam logic [TMOW-1:0] TmoLast = TMOW'(TMO_CYC - 1);

  typedef enum logic [1:0] {StIdle, StSetup, StAccess, StDerr} state_e;

  state_e              r_state;
  state_e              w_state_nxt;

  logic [31:0]         r_addr;
  logic                r_write;
  logic [PDATAW-1:0]   r_wdata;
  logic [PSTRBW-1:0]   r_strb;
  logic [2:0]          r_prot;
  logic [IDXW-1:0]     r_idx;
  logic [TMOW-1:0]     r_tmo_cnt;

  logic                r_rsp_valid;
  logic [PDATAW-1:0]   r_rsp_rdata;
  logic                r_rsp_err;
  logic                r_rsp_tmo;

  logic                w_accept;
  logic [31:0]         w_slot;
  logic                w_req_derr;
  logic                w_sel_ready;
  logic                w_sel_err;
  logic [PDATAW-1:0]   w_sel_rdata;
  logic [NS-1:0]       w_psel_dec;
  logic                w_tmo_hit;
  logic                w_busy;

  logic                w_rsp_valid;
  logic [PDATAW-1:0]   w_rsp_rdata;
  logic                w_rsp_err;
  logic                w_rsp_tmo;

  // Any address bit above the slave windows that names a slot >= NS is a decode error.
  assign w_slot     = i_req_addr >> SLVAW;
  assign w_req_derr = (w_slot >= NS);
  assign w_accept   = (r_state == StIdle) && i_req_valid;

  // Selected-slave return path and one-hot select decode.
  always_comb begin
    w_sel_ready = 1'b0;
    w_sel_err   = 1'b0;
    w_sel_rdata = '0;
    w_psel_dec  = '0;
    for (int i = 0; i < NS; i++) begin
      if (r_idx == IDXW'(i)) begin
        w_sel_ready   = i_pready[i];
        w_sel_err     = i_pslverr[i];
        w_sel_rdata   = i_prdata[i*PDATAW +: PDATAW];
        w_psel_dec[i] = 1'b1;
      end
    end
  end

  assign w_tmo_hit = (r_state == StAccess) && !w_sel_ready && (r_tmo_cnt == TmoLast);

  // State register
  always_ff @(posedge i_pclk) begin
    if (!i_preset_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle: begin
        if (i_req_valid) begin
          w_state_nxt = w_req_derr ? StDerr : StSetup;
        end
      end
      StSetup:  w_state_nxt = StAccess;
      StAccess: begin
        if (w_sel_ready || w_tmo_hit) begin
          w_state_nxt = StIdle;
        end
      end
      StDerr:   w_state_nxt = StIdle;
      default:  w_state_nxt = StIdle;
    endcase
  end

  // Output logic
  always_comb begin
    w_busy      = (r_state == StSetup) || (r_state == StAccess);
    o_req_ready = (r_state == StIdle);
    o_penable   = (r_state == StAccess);
    o_psel      = w_busy ? w_psel_dec : '0;
    o_paddr     = w_busy ? r_addr : '0;
    o_pwrite    = w_busy && r_write;
    o_pwdata    = (w_busy && r_write) ? r_wdata : '0;
    o_pstrb     = (w_busy && r_write) ? r_strb : '0;
    o_pprot     = w_busy ? r_prot : '0;
    o_rsp_valid = r_rsp_valid;
    o_rsp_rdata = r_rsp_rdata;
    o_rsp_err   = r_rsp_err;
    o_rsp_tmo   = r_rsp_tmo;
  end

  // Response for the transfer that finishes at this edge; all zero otherwise.
  always_comb begin
    w_rsp_valid = 1'b0;
    w_rsp_rdata = '0;
    w_rsp_err   = 1'b0;
    w_rsp_tmo   = 1'b0;
    if (r_state == StAccess && w_sel_ready) begin
      w_rsp_valid = 1'b1;
      w_rsp_err   = w_sel_err;
      if (!r_write && !w_sel_err) begin
        w_rsp_rdata = w_sel_rdata;
      end
    end else if (w_tmo_hit) begin
      w_rsp_valid = 1'b1;
      w_rsp_err   = 1'b1;
      w_rsp_tmo   = 1'b1;
    end else if (r_state == StDerr) begin
      w_rsp_valid = 1'b1;
      w_rsp_err   = 1'b1;
    end
  end

  always_ff @(posedge i_pclk) begin
    if (!i_preset_n) begin
      r_addr  <= '0;
      r_write <= 1'b0;
      r_wdata <= '0;
      r_strb  <= '0;
      r_prot  <= '0;
      r_idx   <= '0;
    end else if (w_accept) begin
      r_addr  <= i_req_addr;
      r_write <= i_req_write;
      r_wdata <= i_req_wdata;
      r_strb  <= i_req_strb;
      r_prot  <= i_req_prot;
      r_idx   <= i_req_addr[SLVAW +: IDXW];
    end
  end

  // Counts ACCESS wait cycles; saturates at the timeout threshold.
  always_ff @(posedge i_pclk) begin
    if (!i_preset_n) begin
      r_tmo_cnt <= '0;
    end else if (w_state_nxt == StSetup) begin
      r_tmo_cnt <= '0;
    end else if (r_state == StAccess && !w_sel_ready && r_tmo_cnt != TmoLast) begin
      r_tmo_cnt <= r_tmo_cnt + 1'b1;
    end
  end

  always_ff @(posedge i_pclk) begin
    if (!i_preset_n) begin
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
      r_rsp_tmo   <= 1'b0;
    end else begin
      r_rsp_valid <= w_rsp_valid;
      r_rsp_rdata <= w_rsp_rdata;
      r_rsp_err   <= w_rsp_err;
      r_rsp_tmo   <= w_rsp_tmo;
    end
  end

endmodule
